// File: rtl/retire_arch_map_pkg.sv
// Shared types and sizing for the 2-wide retire stage and its architectural map.
package retire_arch_map_pkg;

    localparam int N_ENTRY_ROB = 32;
    localparam int N_PHYS      = N_ENTRY_ROB + 33;
    localparam int PTAG_W      = $clog2(N_PHYS);
    localparam int N_ARCH      = 32;
    localparam int IDX_W       = 5;

    localparam logic [IDX_W-1:0] ZERO_IDX = 5'd31;

    // One ROB head slot as seen by the retire stage.
    typedef struct packed {
        logic              valid;
        logic              complete;
        logic [IDX_W-1:0]  dest_idx;
        logic [PTAG_W-1:0] Tnew;
        logic [PTAG_W-1:0] Told;
        logic [63:0]       NPC;
        logic              mispredict;
        logic              halt;
    } rob_head_t;

endpackage

// File: rtl/retire_arch_map_table.sv
// 32-entry architectural map: identity on reset, two ordered write ports
// (port 1 wins on a shared index) and a combinational next-state view.
module retire_arch_map_table
    import retire_arch_map_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we0_i,
    input  logic [IDX_W-1:0]               idx0_i,
    input  logic [PTAG_W-1:0]              tag0_i,
    input  logic                           we1_i,
    input  logic [IDX_W-1:0]               idx1_i,
    input  logic [PTAG_W-1:0]              tag1_i,
    output logic [N_ARCH-1:0][PTAG_W-1:0]  map_q_o,
    output logic [N_ARCH-1:0][PTAG_W-1:0]  map_d_o
);

    genvar gi;
    generate
        for (gi = 0; gi < N_ARCH; gi++) begin : g_entry
            logic [PTAG_W-1:0] entry_d;
            logic [PTAG_W-1:0] entry_q;

            // Next value: the younger write port overrides the older one.
            always_comb begin
                entry_d = entry_q;
                if (we0_i && (idx0_i == IDX_W'(gi))) begin
                    entry_d = tag0_i;
                end
                if (we1_i && (idx1_i == IDX_W'(gi))) begin
                    entry_d = tag1_i;
                end
            end

            // Entry register, reset to the identity mapping.
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_q <= PTAG_W'(gi);
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign map_q_o[gi] = entry_q;
            assign map_d_o[gi] = entry_d;
        end
    endgenerate

endmodule

// File: rtl/retire_arch_map.sv
// 2-wide in-order retire stage: picks retiring ROB head slots, drives trace
// and free-list outputs, and maintains the architectural map, halt and count.
module retire_arch_map
    import retire_arch_map_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           head_valid_0,
    input  logic                           head_valid_1,
    input  logic                           head_complete_0,
    input  logic                           head_complete_1,
    input  logic [IDX_W-1:0]               head_dest_idx_0,
    input  logic [IDX_W-1:0]               head_dest_idx_1,
    input  logic [PTAG_W-1:0]              head_Tnew_0,
    input  logic [PTAG_W-1:0]              head_Tnew_1,
    input  logic [PTAG_W-1:0]              head_Told_0,
    input  logic [PTAG_W-1:0]              head_Told_1,
    input  logic [63:0]                    head_NPC_0,
    input  logic [63:0]                    head_NPC_1,
    input  logic                           head_mispredict_0,
    input  logic                           head_mispredict_1,
    input  logic                           head_halt_0,
    input  logic                           head_halt_1,
    output logic                           retire_en_0,
    output logic                           retire_en_1,
    output logic                           valid_0,
    output logic                           valid_1,
    output logic [IDX_W-1:0]               wr_idx_0,
    output logic [IDX_W-1:0]               wr_idx_1,
    output logic [PTAG_W-1:0]              Tnew_out_0,
    output logic [PTAG_W-1:0]              Tnew_out_1,
    output logic [63:0]                    retire_NPC_0,
    output logic [63:0]                    retire_NPC_1,
    output logic                           free_valid_0,
    output logic                           free_valid_1,
    output logic [PTAG_W-1:0]              free_tag_0,
    output logic [PTAG_W-1:0]              free_tag_1,
    output logic                           flush,
    output logic [N_ARCH-1:0][PTAG_W-1:0]  recover_map,
    output logic [N_ARCH-1:0][PTAG_W-1:0]  arch_tag,
    output logic                           halted,
    output logic [63:0]                    retired_count
);

    rob_head_t head_0;
    rob_head_t head_1;

    assign head_0 = '{valid: head_valid_0, complete: head_complete_0,
                      dest_idx: head_dest_idx_0, Tnew: head_Tnew_0,
                      Told: head_Told_0, NPC: head_NPC_0,
                      mispredict: head_mispredict_0, halt: head_halt_0};
    assign head_1 = '{valid: head_valid_1, complete: head_complete_1,
                      dest_idx: head_dest_idx_1, Tnew: head_Tnew_1,
                      Told: head_Told_1, NPC: head_NPC_1,
                      mispredict: head_mispredict_1, halt: head_halt_1};

    logic        halted_q;
    logic        halted_d;
    logic [63:0] count_q;
    logic [63:0] count_d;
    logic        r0;
    logic        r1;
    logic        we0;
    logic        we1;
    logic [N_ARCH-1:0][PTAG_W-1:0] map_d;

    // Retire decision: slot 1 only follows a retiring, non-redirecting slot 0.
    // Reset suppresses everything so a mid-stream reset drops the cycle's retires.
    always_comb begin
        r0 = !rst && head_0.valid && head_0.complete && !halted_q;
        r1 = r0 && !head_0.mispredict && !head_0.halt
                && head_1.valid && head_1.complete;
        we0 = r0 && (head_0.dest_idx != ZERO_IDX);
        we1 = r1 && (head_1.dest_idx != ZERO_IDX);
    end

    // Per-slot trace and free-list outputs, zeroed for non-retiring slots.
    always_comb begin
        retire_en_0  = r0;
        retire_en_1  = r1;
        valid_0      = r0;
        valid_1      = r1;
        wr_idx_0     = r0 ? head_0.dest_idx : ZERO_IDX;
        wr_idx_1     = r1 ? head_1.dest_idx : ZERO_IDX;
        Tnew_out_0   = r0 ? head_0.Tnew : '0;
        Tnew_out_1   = r1 ? head_1.Tnew : '0;
        retire_NPC_0 = r0 ? head_0.NPC : '0;
        retire_NPC_1 = r1 ? head_1.NPC : '0;
        free_valid_0 = we0;
        free_valid_1 = we1;
        free_tag_0   = we0 ? head_0.Told : '0;
        free_tag_1   = we1 ? head_1.Told : '0;
        flush        = (r0 && head_0.mispredict) || (r1 && head_1.mispredict);
        recover_map  = rst ? '0 : map_d;
    end

    // Next-state halt flag and retire count.
    always_comb begin
        halted_d = halted_q || (r0 && head_0.halt) || (r1 && head_1.halt);
        count_d  = count_q + 64'(r0) + 64'(r1);
    end

    // Sticky halt and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign halted        = halted_q;
    assign retired_count = count_q;

    retire_arch_map_table u_map (
        .clk     (clk),
        .rst     (rst),
        .we0_i   (we0),
        .idx0_i  (head_0.dest_idx),
        .tag0_i  (head_0.Tnew),
        .we1_i   (we1),
        .idx1_i  (head_1.dest_idx),
        .tag1_i  (head_1.Tnew),
        .map_q_o (arch_tag),
        .map_d_o (map_d)
    );

endmodule

// File: tb/tb_retire_arch_map.sv
// Directed bench for the retire stage: hand-computed expectations per step.
module tb_retire_arch_map;
    import retire_arch_map_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic hv0, hv1, hc0, hc1, hm0, hm1, hh0, hh1;
    logic [IDX_W-1:0]  hd0, hd1;
    logic [PTAG_W-1:0] htn0, htn1, hto0, hto1;
    logic [63:0]       hn0, hn1;

    logic re0, re1, v0, v1, fv0, fv1, flush, halted;
    logic [IDX_W-1:0]  wi0, wi1;
    logic [PTAG_W-1:0] to0, to1, ft0, ft1;
    logic [63:0]       rn0, rn1, rcount;
    logic [N_ARCH-1:0][PTAG_W-1:0] rmap, amap;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    retire_arch_map dut (
        .clk(clk), .rst(rst),
        .head_valid_0(hv0), .head_valid_1(hv1),
        .head_complete_0(hc0), .head_complete_1(hc1),
        .head_dest_idx_0(hd0), .head_dest_idx_1(hd1),
        .head_Tnew_0(htn0), .head_Tnew_1(htn1),
        .head_Told_0(hto0), .head_Told_1(hto1),
        .head_NPC_0(hn0), .head_NPC_1(hn1),
        .head_mispredict_0(hm0), .head_mispredict_1(hm1),
        .head_halt_0(hh0), .head_halt_1(hh1),
        .retire_en_0(re0), .retire_en_1(re1),
        .valid_0(v0), .valid_1(v1),
        .wr_idx_0(wi0), .wr_idx_1(wi1),
        .Tnew_out_0(to0), .Tnew_out_1(to1),
        .retire_NPC_0(rn0), .retire_NPC_1(rn1),
        .free_valid_0(fv0), .free_valid_1(fv1),
        .free_tag_0(ft0), .free_tag_1(ft1),
        .flush(flush), .recover_map(rmap), .arch_tag(amap),
        .halted(halted), .retired_count(rcount)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        hv0 = 0; hv1 = 0; hc0 = 0; hc1 = 0; hm0 = 0; hm1 = 0; hh0 = 0; hh1 = 0;
        hd0 = 0; hd1 = 0; htn0 = 0; htn1 = 0; hto0 = 0; hto1 = 0; hn0 = 0; hn1 = 0;
    endtask

    task automatic slot0(input logic c, input logic [4:0] d, input logic [6:0] tn,
                         input logic [6:0] to, input logic [63:0] n);
        hv0 = 1; hc0 = c; hd0 = d; htn0 = tn; hto0 = to; hn0 = n;
    endtask

    task automatic slot1(input logic c, input logic [4:0] d, input logic [6:0] tn,
                         input logic [6:0] to, input logic [63:0] n);
        hv1 = 1; hc1 = c; hd1 = d; htn1 = tn; hto1 = to; hn1 = n;
    endtask

    // Advance one edge and settle just after it; new inputs apply from here.
    task automatic step(input string what);
        @(posedge clk);
        #1;
        $display("[TB] step: %s", what);
    endtask

    initial begin
        idle();
        rst = 1;
        step("reset");
        step("reset");
        // Reset overrides a ready retire
        slot0(1, 5'd6, 7'd33, 7'd6, 64'h10);
        #1;
        chk("rst_re0", re0, 0);
        chk("rst_wi0", wi0, 31);
        chk("rst_ft0", ft0, 0);
        idle();
        rst = 0;
        step("idle after reset");
        chk("idle_at5", amap[5], 5);
        chk("idle_at31", amap[31], 31);
        chk("idle_v0", v0, 0);
        chk("idle_v1", v1, 0);
        chk("idle_wi0", wi0, 31);
        chk("idle_cnt", rcount, 0);

        // Two-wide retire, distinct dests
        slot0(1, 5'd3, 7'd40, 7'd3, 64'h100);
        slot1(1, 5'd7, 7'd41, 7'd7, 64'h104);
        #1;
        chk("t2_re0", re0, 1);
        chk("t2_re1", re1, 1);
        chk("t2_fv0", fv0, 1);
        chk("t2_ft0", ft0, 3);
        chk("t2_ft1", ft1, 7);
        chk("t2_wi1", wi1, 7);
        chk("t2_to0", to0, 40);
        chk("t2_npc1", rn1, 64'h104);
        chk("t2_flush", flush, 0);
        step("retire dest 3/7");
        idle();
        #1;
        chk("t2_at3", amap[3], 40);
        chk("t2_at7", amap[7], 41);
        chk("t2_cnt", rcount, 2);

        // Same dest in both slots
        slot0(1, 5'd4, 7'd50, 7'd4, 64'h108);
        slot1(1, 5'd4, 7'd51, 7'd50, 64'h10c);
        #1;
        chk("t3_fv0", fv0, 1);
        chk("t3_fv1", fv1, 1);
        chk("t3_ft0", ft0, 4);
        chk("t3_ft1", ft1, 50);
        chk("t3_rmap4", rmap[4], 51);
        step("retire same dest 4");
        idle();
        #1;
        chk("t3_at4", amap[4], 51);
        chk("t3_cnt", rcount, 4);

        // Incomplete slot 0 blocks a complete slot 1
        slot0(0, 5'd8, 7'd44, 7'd8, 64'h110);
        slot1(1, 5'd9, 7'd45, 7'd9, 64'h114);
        #1;
        chk("t4_re0", re0, 0);
        chk("t4_re1", re1, 0);
        chk("t4_fv1", fv1, 0);
        chk("t4_wi1", wi1, 31);
        step("slot 0 incomplete");
        #1;
        chk("t4_at9", amap[9], 9);
        chk("t4_cnt", rcount, 4);
        hc0 = 1;
        #1;
        chk("t4b_re0", re0, 1);
        chk("t4b_re1", re1, 1);
        step("slot 0 completes");
        idle();
        #1;
        chk("t4b_at8", amap[8], 44);
        chk("t4b_at9", amap[9], 45);
        chk("t4b_cnt", rcount, 6);

        // Slot 0 mispredict blocks slot 1, recover_map reflects this cycle
        slot0(1, 5'd2, 7'd60, 7'd2, 64'h1000);
        hm0 = 1;
        slot1(1, 5'd10, 7'd61, 7'd10, 64'h1004);
        #1;
        chk("t5_re0", re0, 1);
        chk("t5_re1", re1, 0);
        chk("t5_flush", flush, 1);
        chk("t5_npc0", rn0, 64'h1000);
        chk("t5_rmap2", rmap[2], 60);
        chk("t5_rmap3", rmap[3], 40);
        chk("t5_rmap10", rmap[10], 10);
        step("mispredict slot 0");
        idle();
        #1;
        chk("t5_at2", amap[2], 60);
        chk("t5_at10", amap[10], 10);
        chk("t5_cnt", rcount, 7);

        // Mispredict in slot 1 still retires both and flushes
        slot0(1, 5'd11, 7'd62, 7'd11, 64'h1008);
        slot1(1, 5'd12, 7'd63, 7'd12, 64'h2000);
        hm1 = 1;
        #1;
        chk("t5b_re1", re1, 1);
        chk("t5b_flush", flush, 1);
        chk("t5b_rmap12", rmap[12], 63);
        step("mispredict slot 1");
        idle();
        #1;
        chk("t5b_cnt", rcount, 9);

        // Halt in slot 0 with zero-register dest
        slot0(1, 5'd31, 7'd64, 7'd31, 64'h2004);
        hh0 = 1;
        slot1(1, 5'd13, 7'd20, 7'd13, 64'h2008);
        #1;
        chk("t6_re0", re0, 1);
        chk("t6_re1", re1, 0);
        chk("t6_fv0", fv0, 0);
        chk("t6_wi0", wi0, 31);
        chk("t6_halted_pre", halted, 0);
        step("halt slot 0");
        idle();
        #1;
        chk("t6_halted", halted, 1);
        chk("t6_cnt", rcount, 10);
        chk("t6_at31", amap[31], 31);
        chk("t6_at13", amap[13], 13);
        slot0(1, 5'd14, 7'd21, 7'd14, 64'h200c);
        slot1(1, 5'd15, 7'd22, 7'd15, 64'h2010);
        #1;
        chk("t6_post_re0", re0, 0);
        chk("t6_post_fv0", fv0, 0);
        step("complete after halt");
        #1;
        chk("t6_post_cnt", rcount, 10);
        chk("t6_post_at14", amap[14], 14);

        // Mid-stream reset with a retire-ready head
        hh0 = 0;
        rst = 1;
        #1;
        chk("t6_rst_re0", re0, 0);
        step("mid-stream reset");
        rst = 0;
        idle();
        #1;
        chk("t6_rst_at2", amap[2], 2);
        chk("t6_rst_at4", amap[4], 4);
        chk("t6_rst_halted", halted, 0);
        chk("t6_rst_cnt", rcount, 0);
        step("idle after reset");
        chk("t6_rst_at14", amap[14], 14);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/retire_arch_map.md
Name: retire_arch_map

Overview:
- 2-wide in-order retire stage. Sits between the ROB head and the architectural-state consumers (writeback trace register, free list, rename recovery).
- Inspects the two oldest ROB entries each cycle and decides which of them retire.
- Drives per-slot retire valid, dest index, Tnew and NPC.
- Frees Told tags, maintains the registered architectural map (arch tag per logical register) and signals mispredict flush and halt.

Parameters:
N_ENTRY_ROB, 32, ROB entries.
N_PHYS, N_ENTRY_ROB+33, physical register count.
PTAG_W, $clog2(N_PHYS), physical tag width (7 at defaults).
ZERO_IDX, 5'd31, logical zero register.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
head_valid_0/1  in  1  ROB slot holds an instruction (slot 0 is oldest)
head_complete_0/1  in  1  instruction has executed
head_dest_idx_0/1  in  5  logical destination
head_Tnew_0/1  in  PTAG_W  new physical tag
head_Told_0/1  in  PTAG_W  previous physical tag of dest
head_NPC_0/1  in  64  next PC of instruction
head_mispredict_0/1  in  1  branch resolved mispredicted
head_halt_0/1  in  1  instruction is halt
retire_en_0/1  out  1  pop slot from ROB this cycle
valid_0/1  out  1  retire valid to trace register (same as retire_en)
wr_idx_0/1  out  5  retired dest, ZERO_IDX when invalid
Tnew_out_0/1  out  PTAG_W  retired Tnew, 0 when invalid
retire_NPC_0/1  out  64  retired NPC, 0 when invalid
free_valid_0/1  out  1  Told returned to free list
free_tag_0/1  out  PTAG_W  tag freed
flush  out  1  mispredict retired this cycle
recover_map  out  32xPTAG_W  next-state architectural map, for rename recovery
arch_tag  out  32xPTAG_W  registered architectural map
halted  out  1  sticky halt retired
retired_count  out  64  instructions retired since reset

Behaviour:
- Reset, synchronous: arch_tag[i]=i for all i; halted=0; retired_count=0.
- While rst=1, every combinational output is forced to 0, and wr_idx to ZERO_IDX.
- Reset asserted mid-stream overrides any retire in that cycle.
- Slot 0 retires (r0) = head_valid_0 & head_complete_0 & !halted.
- Slot 1 retires (r1) = r0 & !head_mispredict_0 & !head_halt_0 & head_valid_1 & head_complete_1.
- Strict in-order: slot 1 never retires alone.
- All retire outputs are combinational in the same cycle as r0/r1. The downstream consumer registers them.
- Architectural map update:
  - Applies at the clock edge.
  - A retiring slot with dest!=ZERO_IDX writes arch_tag[dest]=Tnew.
  - Same dest in both slots: slot 1 value wins.
  - dest==ZERO_IDX: no map write, free_valid=0, arch_tag[31] stays 31 forever.
- Free list: free_valid_k = rk & dest_k!=ZERO_IDX; free_tag_k = Told_k.
  - Same-dest pairs free both tags; slot 1's Told equals slot 0's Tnew by rename.
- flush = (r0 & mispredict_0) | (r1 & mispredict_1).
  - Same cycle as the retire.
  - recover_map equals the arch map after this cycle's writes.
  - Slot 0 mispredict blocks slot 1.
- Halt: a retiring halt sets halted at the edge. The halt itself counts as retired.
  - Afterwards r0=r1=0 until reset.
  - Halt in slot 0 blocks slot 1.
- retired_count += r0 + r1, wrapping at 2^64.
- Incomplete slot 0 with complete slot 1: nothing retires.

Decomposition:
- Shared package: PTAG_W, N_PHYS, ZERO_IDX and a rob_head_t struct {valid, complete, dest_idx, Tnew, Told, NPC, mispredict, halt}.
- One natural sub-module, arch_map_table: the 32-entry map with two ordered write ports (slot 1 priority), reset to identity, and combinational next-state output feeding recover_map.

Test Plan:
1. Reset, then idle → arch_tag[5]=5, arch_tag[31]=31; all valids 0; wr_idx=31; retired_count=0.
2. Both complete, dest 3/7, Tnew 40/41, Told 3/7:
   - retire_en=11, free tags 3 and 7.
   - Next cycle arch_tag[3]=40, arch_tag[7]=41; retired_count=2.
3. Same dest 4 in both slots, Tnew 50/51, Told 4/50 → arch_tag[4]=51; both free_valid with tags 4 and 50.
4. Slot 0 incomplete, slot 1 complete → retire_en=00, no map change.
   - Next cycle slot 0 completes → retire_en=11.
5. Slot 0 mispredict, NPC 0x1000, dest 2, Tnew 60 →
   - retire_en=10, flush=1, recover_map[2]=60 in the same cycle.
   - Slot 1 not retired.
6. Slot 0 halt (dest 31) with slot 1 valid:
   - retire_en=10, free_valid_0=0, halted=1 next cycle.
   - Later completes are ignored; count stops.
   - Assert rst mid-stream → identity map restored, halted=0.
